// File: rtl/cpu_pkg.sv
// Shared CPU constants and the PC source enumeration.
// No logic; types and defaults only.
// Used by the fetch-stage PC unit and by trace tooling.
package cpu_pkg;

  localparam int          PC_WIDTH      = 32;
  localparam int          INST_BYTES    = 4;
  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DFLT  = 32'h0000_4180;

  // Which request produced the next fetch address.
  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_J,
    SRC_JR,
    SRC_EXC
  } pc_src_e;

endpackage

// File: rtl/pc_unit_if.sv
// Redirect-request inputs and PC outputs of the fetch PC unit.
// Pure wiring; no latency.
// No handshake: stall is the only flow-control signal.
interface pc_unit_if import cpu_pkg::*; #(
  parameter int WIDTH = PC_WIDTH
);
  logic             stall;
  logic             br_taken;
  logic [WIDTH-1:0] br_base;
  logic [15:0]      br_off;
  logic             jump;
  logic [25:0]      jump_idx;
  logic             jr;
  logic [WIDTH-1:0] jr_tgt;
  logic             exc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic             redir_pend;
  logic             addr_err;

  // Pipeline control side: issues redirects, observes the PC.
  modport master (
    output stall, br_taken, br_base, br_off, jump, jump_idx, jr, jr_tgt, exc,
    input  pc, pc_plus, redir_pend, addr_err
  );

  // PC unit side.
  modport slave (
    input  stall, br_taken, br_base, br_off, jump, jump_idx, jr, jr_tgt, exc,
    output pc, pc_plus, redir_pend, addr_err
  );
endinterface

// File: rtl/pc_target_calc.sv
// Computes sequential, branch and jump targets plus the JR misalignment flag.
// Purely combinational, zero latency.
// No backpressure.
module pc_target_calc #(
  parameter int WIDTH = 32,
  parameter int INC   = 4
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] br_base,
  input  logic [15:0]      br_off,
  input  logic [25:0]      jump_idx,
  input  logic [1:0]       jr_tgt_lo,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] br_tgt,
  output logic [WIDTH-1:0] j_tgt,
  output logic             jr_misalign
);
  logic [WIDTH-1:0] off_ext;

  // Word offset sign-extended and scaled to bytes; all sums wrap silently.
  assign off_ext     = {{(WIDTH-18){br_off[15]}}, br_off, 2'b00};
  assign pc_plus     = pc + WIDTH'(INC);
  assign br_tgt      = br_base + off_ext;
  assign jr_misalign = |jr_tgt_lo;

  // Jump keeps the region bits above bit 27 of the delay-slot PC, if any exist.
  generate
    if (WIDTH > 28) begin : g_region
      assign j_tgt = {br_base[WIDTH-1:28], jump_idx, 2'b00};
    end else begin : g_flat
      assign j_tgt = {jump_idx, 2'b00};
    end
  endgenerate
endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with prioritised redirect selection and a stall-time redirect latch.
// Redirect visible on pc one cycle after it is presented, or the cycle after stall drops.
// stall holds pc and parks the youngest redirect; exc flushes regardless of stall.
module pc_unit import cpu_pkg::*; #(
  parameter int          WIDTH    = PC_WIDTH,
  parameter int          INC      = INST_BYTES,
  parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  pc_unit_if.slave   bus
);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] EXC_W = WIDTH'(EXC_VEC);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_q, pend_d;
  logic             addr_err_q, addr_err_d;
  logic [WIDTH-1:0] pc_plus, br_tgt, j_tgt, req_tgt;
  logic             jr_misalign, req_v;
  pc_src_e          src;

  pc_target_calc #(.WIDTH(WIDTH), .INC(INC)) u_calc (
    .pc          (pc_q),
    .br_base     (bus.br_base),
    .br_off      (bus.br_off),
    .jump_idx    (bus.jump_idx),
    .jr_tgt_lo   (bus.jr_tgt[1:0]),
    .pc_plus     (pc_plus),
    .br_tgt      (br_tgt),
    .j_tgt       (j_tgt),
    .jr_misalign (jr_misalign)
  );

  // Priority selector: exc > jr > jump > branch; misaligned JR is diverted to the vector.
  always_comb begin
    src = SRC_SEQ;
    if (bus.exc)           src = SRC_EXC;
    else if (bus.jr)       src = SRC_JR;
    else if (bus.jump)     src = SRC_J;
    else if (bus.br_taken) src = SRC_BR;

    req_tgt = pc_plus;
    case (src)
      SRC_EXC: req_tgt = EXC_W;
      SRC_JR:  req_tgt = jr_misalign ? EXC_W : bus.jr_tgt;
      SRC_J:   req_tgt = j_tgt;
      SRC_BR:  req_tgt = br_tgt;
      default: req_tgt = pc_plus;
    endcase
    req_v = (src != SRC_SEQ);
  end

  // Next-state rules: flush, park under stall, live request, replay parked, sequential.
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    addr_err_d = (src == SRC_JR) && jr_misalign;
    if (bus.exc) begin
      pc_d   = EXC_W;
      pend_d = 1'b0;
    end else if (bus.stall) begin
      if (req_v) begin
        pend_tgt_d = req_tgt;
        pend_d     = 1'b1;
      end
    end else if (req_v) begin
      pc_d   = req_tgt;
      pend_d = 1'b0;
    end else if (pend_q) begin
      pc_d   = pend_tgt_q;
      pend_d = 1'b0;
    end else begin
      pc_d = pc_plus;
    end
  end

  // State registers; reset drops any parked redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RST_W;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_plus    = pc_plus;
  assign bus.redir_pend = pend_q;
  assign bus.addr_err   = addr_err_q;
endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit.
// Inputs change 1ns after the rising edge; outputs are checked at the same point.
// Expected values are hand-computed constants.
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_unit_if #(.WIDTH(32)) bus ();

  pc_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.stall = 0; bus.br_taken = 0; bus.br_base = '0; bus.br_off = '0;
    bus.jump = 0; bus.jump_idx = '0; bus.jr = 0; bus.jr_tgt = '0; bus.exc = 0;
  endtask

  task automatic test_reset();
    tick();
    #3 rst = 1'b1;
    #1;
    n_checks++; if (bus.pc !== 32'h3000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", bus.pc, 32'h3000); end
    n_checks++; if (bus.redir_pend !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b expected 0", bus.redir_pend); end
    n_checks++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b expected 0", bus.addr_err); end
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++; if (bus.pc !== 32'h3000 + 32'(4 * i)) begin n_fail++; $display("FAIL seq_%0d: got %h expected %h", i, bus.pc, 32'h3000 + 32'(4 * i)); end
    end
    n_checks++; if (bus.pc_plus !== 32'h3014) begin n_fail++; $display("FAIL pc_plus: got %h expected %h", bus.pc_plus, 32'h3014); end
  endtask

  task automatic test_branch();
    bus.br_taken = 1; bus.br_base = 32'h3008; bus.br_off = 16'hFFFE;
    tick();
    n_checks++; if (bus.pc !== 32'h3000) begin n_fail++; $display("FAIL br_back: got %h expected %h", bus.pc, 32'h3000); end
    bus.br_off = 16'h0003;
    tick();
    n_checks++; if (bus.pc !== 32'h3014) begin n_fail++; $display("FAIL br_fwd: got %h expected %h", bus.pc, 32'h3014); end
    clear_in();
  endtask

  task automatic test_jump_jr();
    bus.jump = 1; bus.jump_idx = 26'h0000C40; bus.br_base = 32'h1000_0004;
    tick();
    n_checks++; if (bus.pc !== 32'h1000_3100) begin n_fail++; $display("FAIL jump: got %h expected %h", bus.pc, 32'h1000_3100); end
    clear_in();
    bus.jr = 1; bus.jr_tgt = 32'h0000_3202;
    tick();
    n_checks++; if (bus.pc !== 32'h4180) begin n_fail++; $display("FAIL jr_misalign_pc: got %h expected %h", bus.pc, 32'h4180); end
    n_checks++; if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL addr_err_set: got %b expected 1", bus.addr_err); end
    clear_in();
    tick();
    n_checks++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL addr_err_clr: got %b expected 0", bus.addr_err); end
    n_checks++; if (bus.pc !== 32'h4184) begin n_fail++; $display("FAIL after_exc_seq: got %h expected %h", bus.pc, 32'h4184); end
    bus.jr = 1; bus.jr_tgt = 32'h0000_5000;
    tick();
    n_checks++; if (bus.pc !== 32'h5000) begin n_fail++; $display("FAIL jr_aligned: got %h expected %h", bus.pc, 32'h5000); end
    n_checks++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL jr_aligned_err: got %b expected 0", bus.addr_err); end
    // jr beats jump
    bus.jr_tgt = 32'h0000_6000; bus.jump = 1; bus.jump_idx = 26'h0000C40; bus.br_base = 32'h0;
    tick();
    n_checks++; if (bus.pc !== 32'h6000) begin n_fail++; $display("FAIL jr_over_jump: got %h expected %h", bus.pc, 32'h6000); end
    // jump beats branch
    bus.jr = 0; bus.br_taken = 1; bus.br_off = 16'h0010;
    tick();
    n_checks++; if (bus.pc !== 32'h3100) begin n_fail++; $display("FAIL jump_over_br: got %h expected %h", bus.pc, 32'h3100); end
    clear_in();
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = bus.pc;
    bus.stall = 1; bus.jump = 1; bus.jump_idx = 26'h0000C40; bus.br_base = 32'h4;
    tick();
    n_checks++; if (bus.pc !== held) begin n_fail++; $display("FAIL stall_hold1: got %h expected %h", bus.pc, held); end
    n_checks++; if (bus.redir_pend !== 1'b1) begin n_fail++; $display("FAIL stall_pend1: got %b expected 1", bus.redir_pend); end
    bus.jump = 0; bus.br_taken = 1; bus.br_base = 32'h3000; bus.br_off = 16'h0080;
    tick();
    n_checks++; if (bus.pc !== held) begin n_fail++; $display("FAIL stall_hold2: got %h expected %h", bus.pc, held); end
    bus.br_taken = 0;
    tick();
    n_checks++; if (bus.pc !== held) begin n_fail++; $display("FAIL stall_hold3: got %h expected %h", bus.pc, held); end
    n_checks++; if (bus.redir_pend !== 1'b1) begin n_fail++; $display("FAIL stall_pend3: got %b expected 1", bus.redir_pend); end
    bus.stall = 0;
    tick();
    n_checks++; if (bus.pc !== 32'h3200) begin n_fail++; $display("FAIL stall_release: got %h expected %h", bus.pc, 32'h3200); end
    n_checks++; if (bus.redir_pend !== 1'b0) begin n_fail++; $display("FAIL stall_pend_clr: got %b expected 0", bus.redir_pend); end
    tick();
    n_checks++; if (bus.pc !== 32'h3204) begin n_fail++; $display("FAIL stall_resume: got %h expected %h", bus.pc, 32'h3204); end
    // live request at release beats the parked one
    bus.stall = 1; bus.jump = 1; bus.jump_idx = 26'h0000C40; bus.br_base = 32'h4;
    tick();
    clear_in();
    bus.br_taken = 1; bus.br_base = 32'h3000; bus.br_off = 16'h0100;
    tick();
    n_checks++; if (bus.pc !== 32'h3400) begin n_fail++; $display("FAIL live_over_pend: got %h expected %h", bus.pc, 32'h3400); end
    n_checks++; if (bus.redir_pend !== 1'b0) begin n_fail++; $display("FAIL live_pend_clr: got %b expected 0", bus.redir_pend); end
    clear_in();
  endtask

  task automatic test_exc();
    bus.stall = 1; bus.jump = 1; bus.jump_idx = 26'h0000C40; bus.br_base = 32'h4;
    tick();
    bus.jump = 0; bus.exc = 1;
    tick();
    n_checks++; if (bus.pc !== 32'h4180) begin n_fail++; $display("FAIL exc_under_stall: got %h expected %h", bus.pc, 32'h4180); end
    n_checks++; if (bus.redir_pend !== 1'b0) begin n_fail++; $display("FAIL exc_pend_clr: got %b expected 0", bus.redir_pend); end
    bus.exc = 0;
    tick();
    n_checks++; if (bus.pc !== 32'h4180) begin n_fail++; $display("FAIL exc_stall_hold: got %h expected %h", bus.pc, 32'h4180); end
    bus.stall = 0;
    tick();
    n_checks++; if (bus.pc !== 32'h4184) begin n_fail++; $display("FAIL exc_no_replay: got %h expected %h", bus.pc, 32'h4184); end
    bus.exc = 1; bus.jr = 1; bus.jr_tgt = 32'h5000; bus.jump = 1;
    tick();
    n_checks++; if (bus.pc !== 32'h4180) begin n_fail++; $display("FAIL exc_priority: got %h expected %h", bus.pc, 32'h4180); end
    n_checks++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL exc_addr_err: got %b expected 0", bus.addr_err); end
    clear_in();
  endtask

  task automatic test_wrap_reset_pend();
    bus.jr = 1; bus.jr_tgt = 32'hFFFF_FFFC;
    tick();
    n_checks++; if (bus.pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_load: got %h expected %h", bus.pc, 32'hFFFF_FFFC); end
    clear_in();
    tick();
    n_checks++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL wrap: got %h expected %h", bus.pc, 32'h0); end
    bus.stall = 1; bus.jump = 1; bus.jump_idx = 26'h0000C40; bus.br_base = 32'h4;
    tick();
    n_checks++; if (bus.redir_pend !== 1'b1) begin n_fail++; $display("FAIL pend_before_rst: got %b expected 1", bus.redir_pend); end
    clear_in();
    bus.stall = 1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.pc !== 32'h3000) begin n_fail++; $display("FAIL rst_mid_pc: got %h expected %h", bus.pc, 32'h3000); end
    n_checks++; if (bus.redir_pend !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pend: got %b expected 0", bus.redir_pend); end
    tick();
    rst = 1'b0; bus.stall = 0;
    tick();
    n_checks++; if (bus.pc !== 32'h3004) begin n_fail++; $display("FAIL rst_no_replay1: got %h expected %h", bus.pc, 32'h3004); end
    tick();
    n_checks++; if (bus.pc !== 32'h3008) begin n_fail++; $display("FAIL rst_no_replay2: got %h expected %h", bus.pc, 32'h3008); end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_branch();
    test_jump_jr();
    test_stall();
    test_exc();
    test_wrap_reset_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
